// File: rtl/vec_div_pkg.sv
// Shared types and sizing for the vector divide issue sequencer.
package vec_div_pkg;

  localparam int VDIV_N     = 19;
  localparam int VDIV_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vdiv_state_t;

  typedef logic signed [VDIV_N-1:0] elem_t;

endpackage

// File: rtl/vec_div_sequencer.sv
// Vector divide issue sequencer: walks one lane per cycle through the
// external combinational divider and returns the packed quotient vector.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a request; start_ready high
//   RUN   | lane idx presented to the divider, written at each edge
//   DONE  | result vector valid, held until res_ready or flush
module vec_div_sequencer
  import vec_div_pkg::*;
#(
  parameter int N     = VDIV_N,
  parameter int LANES = VDIV_LANES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [LANES*N-1:0] vec_a,
  input  logic [LANES*N-1:0] vec_b,
  input  logic [LANES-1:0]   lane_mask,
  input  logic               flush,
  output logic [N-1:0]       div_a,
  output logic [N-1:0]       div_b,
  input  logic [N-1:0]       div_q,
  input  logic               div_ovf,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [LANES*N-1:0] res_vec,
  output logic [LANES-1:0]   res_dz,
  output logic               res_ovf,
  output logic               busy
);

  localparam int            IW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(LANES - 1);

  vdiv_state_t        state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [LANES*N-1:0] a_q, a_d;
  logic [LANES*N-1:0] b_q, b_d;
  logic [LANES*N-1:0] res_q, res_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic [LANES-1:0]   dz_q, dz_d;
  logic               ovf_q, ovf_d;

  logic [N-1:0]       lane_a;
  logic [N-1:0]       lane_b;
  logic               lane_act;
  logic               lane_bz;
  logic               lane_live;

  // Select the operands and mask bit of the current lane.
  always_comb begin
    lane_a   = '0;
    lane_b   = '0;
    lane_act = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (idx_q == IW'(i)) begin
        lane_a   = a_q[i*N +: N];
        lane_b   = b_q[i*N +: N];
        lane_act = mask_q[i];
      end
    end
  end

  assign lane_bz   = (lane_b == '0);
  assign lane_live = lane_act && !lane_bz;

  // The divider must never see a zero divisor, so dead lanes get 1.
  assign div_a = lane_a;
  assign div_b = lane_live ? lane_b : N'(1);

  // Next-state, lane write-back and flag accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    res_d   = res_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        // flush wins over a coincident request
        if (start_valid && !flush) begin
          a_d     = vec_a;
          b_d     = vec_b;
          mask_d  = lane_mask;
          res_d   = '0;
          dz_d    = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (flush) begin
          res_d   = '0;
          dz_d    = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (idx_q == IW'(i)) begin
              res_d[i*N +: N] = lane_live ? div_q : '0;
              dz_d[i]         = lane_act && lane_bz;
            end
          end
          // overflow from a substituted divisor of 1 is meaningless
          if (lane_live) begin
            ovf_d = ovf_q | div_ovf;
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      DONE: begin
        // flush discards the result without a handshake
        if (flush) begin
          res_d   = '0;
          dz_d    = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end else if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      res_q   <= '0;
      dz_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == DONE);
  assign res_vec     = res_q;
  assign res_dz      = dz_q;
  assign res_ovf     = ovf_q;

endmodule

// File: tb/tb_vec_div_sequencer.sv
// Directed bench for vec_div_sequencer with a behavioural signed divider
// (truncation toward zero, low N bits) standing in for the ALU divider.
module tb_vec_div_sequencer;

  localparam int N = 19;
  localparam int L = 4;
  localparam int W = N * L;

  logic           clk;
  logic           rst_n;
  logic           start_valid;
  logic           start_ready;
  logic [W-1:0]   vec_a;
  logic [W-1:0]   vec_b;
  logic [L-1:0]   lane_mask;
  logic           flush;
  logic [N-1:0]   div_a;
  logic [N-1:0]   div_b;
  logic [N-1:0]   div_q;
  logic           div_ovf;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_vec;
  logic [L-1:0]   res_dz;
  logic           res_ovf;
  logic           busy;

  int n_chk = 0;
  int n_bad = 0;

  vec_div_sequencer #(.N(N), .LANES(L)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .vec_a       (vec_a),
    .vec_b       (vec_b),
    .lane_mask   (lane_mask),
    .flush       (flush),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_q       (div_q),
    .div_ovf     (div_ovf),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_vec     (res_vec),
    .res_dz      (res_dz),
    .res_ovf     (res_ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural divider
  int qa, qb, qq;
  always_comb begin
    qa      = int'(signed'(div_a));
    qb      = int'(signed'(div_b));
    qq      = (qb == 0) ? 0 : qa / qb;
    div_q   = qq[N-1:0];
    div_ovf = (div_a == 19'h40000) && (div_b == 19'h7FFFF);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // the divider must never be handed a zero divisor
  always @(negedge clk) chk("divb_nz", W'(div_b != '0), W'(1));

  function automatic logic [W-1:0] pack(input int e0, input int e1, input int e2, input int e3);
    pack = {19'(e3), 19'(e2), 19'(e1), 19'(e0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one request and wait (bounded) for res_valid; lat counts the accept cycle as 1
  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [L-1:0] m,
                         output logic [W-1:0] r, output logic [L-1:0] dz, output logic ov,
                         output int lat, output logic [N-1:0] db2);
    vec_a       = a;
    vec_b       = b;
    lane_mask   = m;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    lat = 1;
    db2 = '0;
    while (!res_valid && lat < 20) begin
      if (lat == 3) db2 = div_b;
      tick();
      lat++;
    end
    r  = res_vec;
    dz = res_dz;
    ov = res_ovf;
  endtask

  task automatic retire();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("retire_busy", W'(busy), W'(0));
    chk("retire_srdy", W'(start_ready), W'(1));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_srdy"}, W'(start_ready), W'(1));
    chk({tag, "_rvld"}, W'(res_valid), W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_rvec"}, res_vec, W'(0));
    chk({tag, "_rdz"}, W'(res_dz), W'(0));
    chk({tag, "_rovf"}, W'(res_ovf), W'(0));
    chk({tag, "_diva"}, W'(div_a), W'(0));
    chk({tag, "_divb"}, W'(div_b), W'(1));
  endtask

  logic [W-1:0] r, exp_r;
  logic [L-1:0] dz;
  logic         ov;
  logic [N-1:0] db2;
  int           lat;
  int           seen;

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    vec_a       = '0;
    vec_b       = '0;
    lane_mask   = '0;
    flush       = 1'b0;
    res_ready   = 1'b0;
    repeat (2) tick();
    chk_reset_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: mixed signs, all lanes active
    run_vec(pack(100, -100, 7, -7), pack(7, 7, -2, -2), 4'b1111, r, dz, ov, lat, db2);
    chk("t1_lat", W'(lat), W'(5));
    chk("t1_q", r, pack(14, -14, -3, 3));
    chk("t1_dz", W'(dz), W'(0));
    chk("t1_ovf", W'(ov), W'(0));
    retire();

    // 2: most-negative / -1 overflow on lane 0
    run_vec(pack(-262144, 1, 1, 1), pack(-1, 1, 1, 1), 4'b1111, r, dz, ov, lat, db2);
    exp_r = {19'd1, 19'd1, 19'd1, 19'h40000};
    chk("t2_q", r, exp_r);
    chk("t2_dz", W'(dz), W'(0));
    chk("t2_ovf", W'(ov), W'(1));
    retire();

    // 3: divide by zero on lane 2
    run_vec(pack(12, 9, 55, -20), pack(5, -4, 0, 3), 4'b1111, r, dz, ov, lat, db2);
    chk("t3_q", r, pack(2, -2, 0, -6));
    chk("t3_dz", W'(dz), W'(4'b0100));
    chk("t3_ovf", W'(ov), W'(0));
    chk("t3_divb_l2", W'(db2), W'(1));
    retire();

    // 6: masked lanes hide a zero divisor and an overflow
    run_vec(pack(10, 8, -9, -262144), pack(3, 0, 4, -1), 4'b0101, r, dz, ov, lat, db2);
    chk("t6_lat", W'(lat), W'(5));
    chk("t6_q", r, pack(3, 0, -2, 0));
    chk("t6_dz", W'(dz), W'(0));
    chk("t6_ovf", W'(ov), W'(0));
    retire();

    // 4: writeback stalls in DONE; a new request is ignored
    run_vec(pack(50, -50, 1, 0), pack(5, 5, 1, 9), 4'b1111, r, dz, ov, lat, db2);
    exp_r = pack(10, -10, 1, 0);
    chk("t4_q", r, exp_r);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        vec_a       = pack(1, 2, 3, 4);
        vec_b       = pack(1, 1, 1, 1);
        lane_mask   = 4'b1111;
        start_valid = 1'b1;
      end
      if (k == 5) start_valid = 1'b0;
      tick();
      chk("t4_hold_q", res_vec, exp_r);
      chk("t4_hold_vld", W'(res_valid), W'(1));
      chk("t4_hold_srdy", W'(start_ready), W'(0));
    end
    retire();
    tick();
    chk("t4_no_second", W'(busy), W'(0));

    // 5a: flush during RUN at idx=2
    vec_a       = pack(100, -100, 7, -7);
    vec_b       = pack(7, 7, -2, -2);
    lane_mask   = 4'b1111;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    chk("t5_idx2_diva", W'(div_a), W'(7));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_fl_busy", W'(busy), W'(0));
    chk("t5_fl_srdy", W'(start_ready), W'(1));
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (res_valid) seen++;
      tick();
    end
    chk("t5_fl_novld", W'(seen), W'(0));

    // 5b: flush in IDLE blocks a coincident request
    flush       = 1'b1;
    start_valid = 1'b1;
    tick();
    flush       = 1'b0;
    start_valid = 1'b0;
    chk("t5_idle_fl", W'(busy), W'(0));

    // 5c: flush beats res_ready in DONE
    run_vec(pack(9, 9, 9, 9), pack(3, 3, 3, 3), 4'b1111, r, dz, ov, lat, db2);
    chk("t5_done_q", r, pack(3, 3, 3, 3));
    flush     = 1'b1;
    res_ready = 1'b1;
    tick();
    flush     = 1'b0;
    res_ready = 1'b0;
    chk("t5_done_busy", W'(busy), W'(0));
    chk("t5_done_vld", W'(res_valid), W'(0));

    // 5d: async reset mid-RUN
    vec_a       = pack(100, -100, 7, -7);
    vec_b       = pack(7, 7, -2, -2);
    lane_mask   = 4'b1111;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // recovery after reset
    run_vec(pack(100, -100, 7, -7), pack(7, 7, -2, -2), 4'b1111, r, dz, ov, lat, db2);
    chk("rec_lat", W'(lat), W'(5));
    chk("rec_q", r, pack(14, -14, -3, 3));
    retire();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
